reg_bypass_scoreboard: RTL and testbench
========================================

Name: reg_bypass_scoreboard

Overview:
- Parametrised successor to the two-port register read proxy. It serves READ_PORTS register-file read ports.
- Per port, it forwards the youngest matching value from FWD_STAGES pipeline stages, or from a long-latency completion bus, or falls back to the regfile.
- An internal scoreboard tracks destination registers of issued multi-cycle ops (mul/div, cache-miss loads). It raises per-port stall requests until each op completes.
- Sits between the ID stage, the regfile and the pipeline control unit.

Parameters:
- READ_PORTS, 2, number of read ports.
- FWD_STAGES, 2, number of bypass sources; index 0 is youngest (EX), highest priority.
- ADDR_W, 5, register address width; the scoreboard holds 2**ADDR_W entries.
- DATA_W, 32, data width.
- CNT_W, 16, width of the stall-cycle statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- read_en  in  READ_PORTS  per-port read enable.
- read_addr  in  READ_PORTS*ADDR_W  per-port address; port p at bits [p*ADDR_W +: ADDR_W].
- reg_data  in  READ_PORTS*DATA_W  regfile read data per port.
- fwd_en  in  FWD_STAGES  stage s writes a register.
- fwd_addr  in  FWD_STAGES*ADDR_W  destination of stage s.
- fwd_data  in  FWD_STAGES*DATA_W  result of stage s.
- fwd_ready  in  FWD_STAGES  fwd_data of stage s is valid this cycle; 0 = load not yet returned.
- issue_en  in  1  long-latency op issued this cycle.
- issue_addr  in  ADDR_W  its destination register.
- cmpl_en  in  1  long-latency result written back this cycle.
- cmpl_addr  in  ADDR_W  completion destination.
- cmpl_data  in  DATA_W  completion result.
- stall_clr  in  1  synchronous clear of stall_cycles.
- read_data  out  READ_PORTS*DATA_W  resolved operand per port.
- stall  out  READ_PORTS  per-port hazard.
- stall_any  out  1  OR of stall.
- busy_count  out  ADDR_W+1  number of busy scoreboard entries.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_any=1.

Behaviour:
- Combinational path per port p, no latency. If read_en[p]=0 or read_addr[p]=0: read_data=0 and stall=0.
- Otherwise the first match in this order wins:
  1. Lowest-index stage s with fwd_en[s] and fwd_addr[s]==addr. If fwd_ready[s]=1, read_data=fwd_data[s]; else read_data=0 and stall[p]=1. An older stage never overrides a younger not-ready match.
  2. cmpl_en with cmpl_addr==addr: read_data=cmpl_data, stall=0, even if the entry is busy.
  3. Scoreboard busy[addr]=1: stall[p]=1, read_data=reg_data[p].
  4. Otherwise read_data=reg_data[p].
- Scoreboard registers busy[2**ADDR_W]; all updates happen on the rising clk edge:
  - issue_en with issue_addr!=0 sets busy[issue_addr].
  - cmpl_en clears busy[cmpl_addr].
  - Same address issued and completed in the same cycle: busy ends at 1 (issue wins; a new op overwrites the destination).
  - Issue to r0 is ignored; busy[0] is always 0.
  - Completion to a non-busy entry is a no-op.
- busy_count is a registered count, updated with the same edge as busy; it always equals the popcount of busy.
- stall_cycles: stall_clr has priority and sets the counter to 0. Otherwise the counter increments when stall_any=1 and saturates at all-ones.
- Reset (asynchronous, rst_n=0 at any time, including mid-op):
  - all busy=0, busy_count=0, stall_cycles=0.
  - Combinational outputs then follow the cleared state: stall=0 unless a not-ready stage match exists.
  - Pending ops are forgotten; a later cmpl_en for them is a harmless no-op.
- Port evaluation is independent: two ports may hit different sources in the same cycle.

Test Plan:
- Priority: fwd0 writes r3=0x11 (ready), fwd1 writes r3=0x22, regfile r3=0x33; read port0 r3 -> read_data0=0x11, stall=0. Drop fwd0 -> 0x22. Drop fwd1 -> 0x33.
- Load-use: fwd0 writes r5 with fwd_ready=0, fwd1 writes r5=0x44 ready -> stall[0]=1 and stall_any=1; stall_cycles increments by 1 per such cycle.
- Scoreboard: issue r7 at cycle 0 -> reads of r7 stall from cycle 1 on, busy_count=1. At cycle 4, cmpl r7=0xDEAD -> read_data=0xDEAD, stall=0 that cycle. From cycle 5, busy_count=0 and reads come from the regfile.
- Same-cycle issue+cmpl on r9 with r9 already busy -> after the edge busy[9]=1 and busy_count unchanged. Issue to r0 -> busy_count unchanged; a read of r0 returns 0, no stall.
- Saturation/clear (CNT_W=4): hold a stall for 20 cycles -> stall_cycles=15. Assert stall_clr -> 0 next edge.
- Async reset: with r2 and r4 busy, pulse rst_n low mid-cycle -> busy_count=0 and stall=0 immediately, without waiting for a clk edge. A subsequent cmpl_en r2 leaves busy_count=0.

Source files
------------

// File: rtl/reg_bypass_scoreboard.sv
// Register read operand resolver for the ID stage.
// Each read port takes its operand from the youngest matching bypass stage,
// then from the long-latency completion bus, then from the regfile. A
// scoreboard of in-flight long-latency destinations raises per-port stalls
// until the matching completion arrives. A saturating counter accumulates
// the number of stalled cycles.
module reg_bypass_scoreboard #(
  parameter int READ_PORTS = 2,
  parameter int FWD_STAGES = 2,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [READ_PORTS-1:0]        read_en,
  input  logic [READ_PORTS*ADDR_W-1:0] read_addr,
  input  logic [READ_PORTS*DATA_W-1:0] reg_data,
  input  logic [FWD_STAGES-1:0]        fwd_en,
  input  logic [FWD_STAGES*ADDR_W-1:0] fwd_addr,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  input  logic [FWD_STAGES-1:0]        fwd_ready,
  input  logic                         issue_en,
  input  logic [ADDR_W-1:0]            issue_addr,
  input  logic                         cmpl_en,
  input  logic [ADDR_W-1:0]            cmpl_addr,
  input  logic [DATA_W-1:0]            cmpl_data,
  input  logic                         stall_clr,
  output logic [READ_PORTS*DATA_W-1:0] read_data,
  output logic [READ_PORTS-1:0]        stall,
  output logic                         stall_any,
  output logic [ADDR_W:0]              busy_count,
  output logic [CNT_W-1:0]             stall_cycles
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [ADDR_W:0] count_nxt;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              stl;
    logic              hit;

    assign addr = read_addr[p*ADDR_W +: ADDR_W];

    // Resolve the operand: stages are scanned oldest to youngest so the
    // youngest match overwrites, including a younger not-ready match that
    // must hide an older ready one.
    always_comb begin
      data = reg_data[p*DATA_W +: DATA_W];
      stl  = 1'b0;
      hit  = 1'b0;
      if (!read_en[p] || addr == '0) begin
        data = '0;
      end else begin
        for (int s = FWD_STAGES - 1; s >= 0; s--) begin
          if (fwd_en[s] && fwd_addr[s*ADDR_W +: ADDR_W] == addr) begin
            hit  = 1'b1;
            stl  = !fwd_ready[s];
            data = fwd_ready[s] ? fwd_data[s*DATA_W +: DATA_W] : '0;
          end
        end
        if (!hit) begin
          if (cmpl_en && cmpl_addr == addr) begin
            data = cmpl_data;
          end else if (busy[addr]) begin
            stl = 1'b1;
          end
        end
      end
    end

    assign read_data[p*DATA_W +: DATA_W] = data;
    assign stall[p]                       = stl;
  end

  assign stall_any = |stall;

  // Next scoreboard state: completion clears, issue sets afterwards so a
  // same-cycle issue to the completing register leaves it busy; r0 never busy.
  always_comb begin
    busy_nxt = busy;
    if (cmpl_en) begin
      busy_nxt[cmpl_addr] = 1'b0;
    end
    if (issue_en && issue_addr != '0) begin
      busy_nxt[issue_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    count_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      count_nxt = count_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  // Scoreboard and its population count move together on the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

  // Stalled-cycle statistic: clear wins, otherwise count and hold at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall_clr) begin
      stall_cycles <= '0;
    end else if (stall_any && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_bypass_scoreboard.sv
// Bench for reg_bypass_scoreboard: directed scenarios followed by random
// traffic, all compared against a behavioural model of the operand rules.
module tb_reg_bypass_scoreboard;

  localparam int RP = 2;
  localparam int FS = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [RP-1:0]    read_en;
  logic [RP*AW-1:0] read_addr;
  logic [RP*DW-1:0] reg_data;
  logic [FS-1:0]    fwd_en;
  logic [FS*AW-1:0] fwd_addr;
  logic [FS*DW-1:0] fwd_data;
  logic [FS-1:0]    fwd_ready;
  logic             issue_en;
  logic [AW-1:0]    issue_addr;
  logic             cmpl_en;
  logic [AW-1:0]    cmpl_addr;
  logic [DW-1:0]    cmpl_data;
  logic             stall_clr;
  logic [RP*DW-1:0] read_data;
  logic [RP-1:0]    stall;
  logic             stall_any;
  logic [AW:0]      busy_count;
  logic [CW-1:0]    stall_cycles;

  always #5 clk = ~clk;

  reg_bypass_scoreboard #(
    .READ_PORTS(RP), .FWD_STAGES(FS), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_addr(read_addr),
    .reg_data(reg_data), .fwd_en(fwd_en), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_ready(fwd_ready), .issue_en(issue_en),
    .issue_addr(issue_addr), .cmpl_en(cmpl_en), .cmpl_addr(cmpl_addr),
    .cmpl_data(cmpl_data), .stall_clr(stall_clr), .read_data(read_data),
    .stall(stall), .stall_any(stall_any), .busy_count(busy_count),
    .stall_cycles(stall_cycles)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: set of registers with an outstanding long-latency op,
  // and the stalled-cycle statistic.
  bit mbusy[32];
  int mcnt;
  bit exp_any;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_popcount();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    mcnt = 0;
  endfunction

  // Operand rules: first stage (youngest first) that matches decides;
  // then the completion bus; then the regfile, stalled if the register is busy.
  function automatic void model_port(input int p, output logic [31:0] d, output logic st);
    logic [AW-1:0] a;
    a  = read_addr[p*AW +: AW];
    d  = '0;
    st = 1'b0;
    if (!read_en[p] || a == 0) return;
    for (int s = 0; s < FS; s++) begin
      if (fwd_en[s] && fwd_addr[s*AW +: AW] == a) begin
        if (fwd_ready[s]) d = fwd_data[s*DW +: DW];
        else st = 1'b1;
        return;
      end
    end
    if (cmpl_en && cmpl_addr == a) begin
      d = cmpl_data;
      return;
    end
    d  = reg_data[p*DW +: DW];
    st = mbusy[a];
  endfunction

  task automatic check_comb(input string tag);
    logic [31:0] d;
    logic        st;
    exp_any = 1'b0;
    for (int p = 0; p < RP; p++) begin
      model_port(p, d, st);
      chk({tag, "_data"}, 64'(read_data[p*DW +: DW]), 64'(d));
      chk({tag, "_stall"}, 64'(stall[p]), 64'(st));
      exp_any |= st;
    end
    chk({tag, "_any"}, 64'(stall_any), 64'(exp_any));
  endtask

  task automatic model_edge();
    if (stall_clr) mcnt = 0;
    else if (exp_any && mcnt < (1 << CW) - 1) mcnt++;
    if (cmpl_en) mbusy[cmpl_addr] = 1'b0;
    if (issue_en && issue_addr != 0) mbusy[issue_addr] = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_bcnt"}, 64'(busy_count), 64'(model_popcount()));
    chk({tag, "_scyc"}, 64'(stall_cycles), 64'(mcnt));
  endtask

  // Inputs are set at posedge+1; combinational outputs are checked before
  // the next edge, registered outputs just after it.
  task automatic cycle(input string tag);
    #2;
    check_comb(tag);
    @(posedge clk);
    model_edge();
    #1;
    check_regs(tag);
  endtask

  task automatic idle();
    read_en = '0; read_addr = '0; reg_data = '0;
    fwd_en = '0; fwd_addr = '0; fwd_data = '0; fwd_ready = '0;
    issue_en = 1'b0; issue_addr = '0;
    cmpl_en = 1'b0; cmpl_addr = '0; cmpl_data = '0; stall_clr = 1'b0;
  endtask

  task automatic rd0(input logic [AW-1:0] a, input logic [31:0] rf);
    read_en[0] = 1'b1;
    read_addr[0 +: AW] = a;
    reg_data[0 +: DW] = rf;
  endtask

  initial begin
    idle();
    model_reset();
    exp_any = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_bcnt", 64'(busy_count), 64'd0);
    chk("rst_scyc", 64'(stall_cycles), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Priority among bypass sources
    rd0(5'd3, 32'h33);
    fwd_en = 2'b11; fwd_ready = 2'b11;
    fwd_addr = {5'd3, 5'd3};
    fwd_data = {32'h22, 32'h11};
    #2 chk("prio_fwd0", 64'(read_data[31:0]), 64'h11);
    chk("prio_fwd0_stall", 64'(stall[0]), 64'd0);
    fwd_en = 2'b10;
    #1 chk("prio_fwd1", 64'(read_data[31:0]), 64'h22);
    fwd_en = 2'b00;
    #1 chk("prio_rf", 64'(read_data[31:0]), 64'h33);
    cycle("prio");

    // Load-use: younger not-ready stage hides older ready one
    idle();
    rd0(5'd5, 32'h55);
    fwd_en = 2'b11; fwd_ready = 2'b10;
    fwd_addr = {5'd5, 5'd5};
    fwd_data = {32'h44, 32'h0};
    #2 chk("lu_stall", 64'(stall[0]), 64'd1);
    chk("lu_any", 64'(stall_any), 64'd1);
    chk("lu_data", 64'(read_data[31:0]), 64'd0);
    cycle("lu1");
    chk("lu_scyc1", 64'(stall_cycles), 64'd1);
    cycle("lu2");
    chk("lu_scyc2", 64'(stall_cycles), 64'd2);
    idle();
    stall_clr = 1'b1;
    cycle("lu_clr");
    chk("lu_clr_scyc", 64'(stall_cycles), 64'd0);

    // Scoreboard: issue r7, complete four cycles later
    idle();
    rd0(5'd7, 32'h77);
    issue_en = 1'b1; issue_addr = 5'd7;
    #2 chk("sb_c0_stall", 64'(stall[0]), 64'd0);
    cycle("sb_c0");
    issue_en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1 chk("sb_wait_stall", 64'(stall[0]), 64'd1);
      chk("sb_wait_bcnt", 64'(busy_count), 64'd1);
      cycle("sb_wait");
    end
    cmpl_en = 1'b1; cmpl_addr = 5'd7; cmpl_data = 32'hDEAD;
    #1 chk("sb_cmpl_data", 64'(read_data[31:0]), 64'hDEAD);
    chk("sb_cmpl_stall", 64'(stall[0]), 64'd0);
    cycle("sb_c4");
    cmpl_en = 1'b0;
    chk("sb_c5_bcnt", 64'(busy_count), 64'd0);
    #1 chk("sb_c5_data", 64'(read_data[31:0]), 64'h77);
    cycle("sb_c5");

    // Same-cycle issue+completion on a busy register; issue to r0
    idle();
    issue_en = 1'b1; issue_addr = 5'd9;
    cycle("sc_issue");
    cmpl_en = 1'b1; cmpl_addr = 5'd9;
    cycle("sc_both");
    chk("sc_bcnt", 64'(busy_count), 64'd1);
    idle();
    rd0(5'd9, 32'h99);
    issue_en = 1'b1; issue_addr = 5'd0;
    read_en[1] = 1'b1; read_addr[AW +: AW] = 5'd0; reg_data[DW +: DW] = 32'hFFFF;
    #1 chk("sc_busy9_stall", 64'(stall[0]), 64'd1);
    chk("r0_data", 64'(read_data[DW +: DW]), 64'd0);
    chk("r0_stall", 64'(stall[1]), 64'd0);
    cycle("r0_issue");
    chk("r0_bcnt", 64'(busy_count), 64'd1);
    idle();
    cmpl_en = 1'b1; cmpl_addr = 5'd9;
    cycle("sc_clean");

    // Saturation and clear of the stall counter
    idle();
    stall_clr = 1'b1;
    issue_en = 1'b1; issue_addr = 5'd6;
    cycle("sat_setup");
    idle();
    rd0(5'd6, 32'h66);
    for (int c = 0; c < 20; c++) cycle("sat_hold");
    chk("sat_15", 64'(stall_cycles), 64'd15);
    stall_clr = 1'b1;
    cycle("sat_clr");
    chk("sat_clr0", 64'(stall_cycles), 64'd0);
    idle();
    cmpl_en = 1'b1; cmpl_addr = 5'd6;
    cycle("sat_clean");

    // Asynchronous reset with outstanding ops
    idle();
    issue_en = 1'b1; issue_addr = 5'd2;
    cycle("ar_i2");
    issue_addr = 5'd4;
    cycle("ar_i4");
    chk("ar_bcnt2", 64'(busy_count), 64'd2);
    idle();
    rd0(5'd2, 32'h22);
    #1 chk("ar_pre_stall", 64'(stall[0]), 64'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("ar_bcnt0", 64'(busy_count), 64'd0);
    chk("ar_stall0", 64'(stall[0]), 64'd0);
    chk("ar_scyc0", 64'(stall_cycles), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    cmpl_en = 1'b1; cmpl_addr = 5'd2;
    cycle("ar_late_cmpl");
    chk("ar_late_bcnt", 64'(busy_count), 64'd0);

    // Random traffic on a small register window to provoke collisions
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int p = 0; p < RP; p++) begin
        read_en[p] = ($urandom_range(0, 7) != 0);
        read_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
        reg_data[p*DW +: DW] = $urandom;
      end
      for (int s = 0; s < FS; s++) begin
        fwd_en[s] = ($urandom_range(0, 2) == 0);
        fwd_addr[s*AW +: AW] = AW'($urandom_range(0, 7));
        fwd_data[s*DW +: DW] = $urandom;
        fwd_ready[s] = ($urandom_range(0, 3) != 0);
      end
      issue_en = ($urandom_range(0, 3) == 0);
      issue_addr = AW'($urandom_range(0, 7));
      cmpl_en = ($urandom_range(0, 2) == 0);
      cmpl_addr = AW'($urandom_range(0, 7));
      cmpl_data = $urandom;
      stall_clr = ($urandom_range(0, 15) == 0);
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
